// File: rtl/multiplier_pkg.sv
// Shared types and helpers for the Booth multiplier product path:
// conversion FSM states, 7-segment constants and the digit encoder.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes render blank.
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD nibble to active-low 7-segment pattern, with a blank override
// used for leading-zero suppression.
module seven_seg_decoder
  import multiplier_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : seg7_encode(digit);

endmodule

// File: rtl/product_display_driver.sv
// Converts the multiplier's signed 8-bit product to sign + 3 BCD digits with a
// sequential double-dabble engine and scans them onto a 4-digit 7-segment display.
module product_display_driver
  import multiplier_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic signed [7:0] prod,
  output logic              busy,
  output logic              bcd_valid,
  output logic [6:0]        seg,
  output logic [3:0]        an
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  // |v| computed at 9 bits so that -128 yields 128 without overflow.
  function automatic logic [7:0] abs_mag(input logic signed [7:0] v);
    logic signed [8:0] w;
    w = {v[7], v};
    if (v[7]) w = -w;
    return w[7:0];
  endfunction

  function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  conv_state_t state;
  logic [2:0]  bit_cnt;
  logic [7:0]  mag;
  logic [11:0] scratch;
  logic        conv_sign;

  logic [3:0]  disp_units;
  logic [3:0]  disp_tens;
  logic [3:0]  disp_hund;
  logic        disp_sign;

  logic [PW-1:0] presc;
  logic [1:0]    idx;

  logic [11:0] scratch_adj;
  logic [19:0] shift_next;

  assign scratch_adj = dabble_adjust(scratch);
  assign shift_next  = {scratch_adj, mag} << 1;
  assign busy        = (state != IDLE);

  // Conversion FSM; scratch/magnitude are pure data and carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      bcd_valid  <= 1'b0;
      disp_units <= 4'd0;
      disp_tens  <= 4'd0;
      disp_hund  <= 4'd0;
      disp_sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CONV;
            bit_cnt <= 3'd0;
          end
        end
        CONV: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          disp_units <= scratch[3:0];
          disp_tens  <= scratch[7:4];
          disp_hund  <= scratch[11:8];
          disp_sign  <= conv_sign;
          bcd_valid  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      conv_sign <= prod[7];
      mag       <= abs_mag(prod);
      scratch   <= 12'd0;
    end else if (state == CONV) begin
      scratch <= shift_next[19:8];
      mag     <= shift_next[7:0];
    end
  end

  // Scan slot selection: digit and leading-zero blanking for the current index.
  logic [3:0] slot_digit;
  logic       slot_blank;
  logic [6:0] dec_seg;
  logic       show_minus;
  logic [6:0] seg_next;
  logic [3:0] an_next;

  assign show_minus = disp_sign && ((disp_units | disp_tens | disp_hund) != 4'd0);

  always_comb begin
    slot_digit = 4'd0;
    slot_blank = 1'b1;
    case (idx)
      2'd0: begin
        slot_digit = disp_units;
        slot_blank = 1'b0;
      end
      2'd1: begin
        slot_digit = disp_tens;
        slot_blank = (disp_hund == 4'd0) && (disp_tens == 4'd0);
      end
      2'd2: begin
        slot_digit = disp_hund;
        slot_blank = (disp_hund == 4'd0);
      end
      default: begin
        slot_digit = 4'd0;
        slot_blank = 1'b1;
      end
    endcase
  end

  seven_seg_decoder u_dec (
    .digit (slot_digit),
    .blank (slot_blank),
    .seg   (dec_seg)
  );

  assign seg_next = (idx == 2'd3) ? (show_minus ? SEG_MINUS : SEG_BLANK) : dec_seg;
  assign an_next  = ~(4'b0001 << idx);

  // Scan output stage: an/seg latch the current slot on each prescaler wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= idx + 2'd1;
      an    <= an_next;
      seg   <= seg_next;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule
